reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- 32-entry register file for the lab pipeline, sitting at the write-back end of the destination-register path.
- The EX-stage 5-bit destination select (rt vs rd) chooses an address; this block is the consumer of that address.
- Decodes the 5-bit write address, stores write-back data on the clock edge, and serves two combinational read ports to the ID stage.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- regwrite  input  1  write enable from the WB stage.
- wr_addr  input  ADDR_W  destination register index (the output of the destination mux).
- wr_data  input  DATA_W  write-back data.
- rd_addr1  input  ADDR_W  read port 1 index (rs).
- rd_addr2  input  ADDR_W  read port 2 index (rt).
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- wr_count  output  8  number of committed writes since reset, saturating at 255.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. There is no asynchronous reset path.
- Reset: on a rising clk edge with rst=1, all 32 registers clear to 0 and wr_count clears to 0.
  - rst has priority over regwrite in the same cycle; the write is dropped.
  - After reset, rd_data1 and rd_data2 read 0 for every address.
- Write: on a rising clk edge with rst=0 and regwrite=1:
  - regs[wr_addr] <= wr_data. Write latency is 1 edge.
  - Only the decoded entry changes; all other entries hold.
- Register 0:
  - Writes with wr_addr=0 are discarded.
  - Reads of address 0 always return 0, regardless of any history.
  - A write to address 0 does not increment wr_count.
- wr_count:
  - Increments by 1 on each accepted write (regwrite=1, rst=0, wr_addr!=0).
  - Holds at 255; never wraps.
- Read: rd_data1/rd_data2 are combinational from rd_addr1/rd_addr2 and the current register contents, with zero clock latency.
  - Both ports may address the same entry; both return the same value.
- X handling:
  - If regwrite is X on an edge, the register contents are a don't-care.
  - If wr_addr contains X bits while regwrite=1, no entry may be written. The implementation must guard with a known-value compare.
  - The bench checks that no register is corrupted in this case.
- Simultaneous read and write to the same nonzero address: governed by the optional feature below.
- Reset mid-operation: asserting rst in the same cycle as a pending write drops that write. Contents are 0 after the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when regwrite=1, rst=0, wr_addr!=0 and wr_addr==rd_addrN (and wr_addr has no X bits), rd_dataN returns wr_data combinationally in the same cycle. This is write-before-read and removes the WB->ID hazard.
- Undefined: rd_dataN returns the stored value. The new value appears only after the clock edge, so the pipeline must stall or forward externally.

Test Plan:
- Reset then read all: rst=1 for 1 edge, then sweep rd_addr1 and rd_addr2 over 0..31 -> all reads 0, wr_count=0.
- Basic write/read: write 0x0000000A to r5 and 0x00000015 to r21 on consecutive edges, then rd_addr1=5, rd_addr2=21 -> 0x0000000A and 0x00000015; wr_count=2.
- r0 protection: regwrite=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data1 at addr 0 = 0; wr_count unchanged.
- Same-cycle read/write: r31 holds 0x1F and rd_addr1=31; write 0x1D to r31.
  - With REGFILE_BYPASS_EN: rd_data1=0x1D before the edge.
  - Without it: rd_data1=0x1F before the edge and 0x1D after it.
- Reset priority: rst=1 and regwrite=1 (r10 <- 0x5) on the same edge -> r10 reads 0, wr_count=0.
- Saturation and X guard:
  - Perform 300 writes to r1 -> wr_count=255.
  - Then drive wr_addr=5'bxxxxx with regwrite=1 -> no register changes, wr_count stays 255.

Source files
------------

// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: bus bundle for the write-back register file.
//   regwrite  : write enable from the WB stage
//   wr_addr   : destination register index
//   wr_data   : write-back data
//   rd_addr1/2: read port indices (rs / rt)
//   rd_data1/2: combinational read data
//   wr_count  : committed-write counter, saturating at 255
// master drives the write/read requests; slave is the register file.
interface reg_file_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regwrite;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [7:0]        wr_count;

  modport master (
    output regwrite, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wr_count
  );

  modport slave (
    input  regwrite, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wr_count
  );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry register file at the write-back end of the pipeline.
// Stores write-back data on the rising clock edge and serves two combinational
// read ports to the ID stage. Register 0 always reads as zero.
//
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous active-high reset (clears registers and wr_count)
//   bus : reg_file_wb_if.slave (write port, two read ports, wr_count)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   : a read of the address being written this cycle returns
//               wr_data combinationally (write-before-read).
//   Undefined : reads return the stored value; new data is visible after
//               the clock edge.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_wb_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [7:0]        count;
  logic              addr_known;
  logic              wr_accept;

  // Known-value guard: a write address carrying X/Z bits must not select any
  // entry. Reduces to constant true in hardware, where X does not exist.
  always_comb begin
    addr_known = 1'b0;
    if (((^bus.wr_addr) === 1'b0) || ((^bus.wr_addr) === 1'b1))
      addr_known = 1'b1;
  end

  // A write commits only with a definitely-high enable, a known nonzero
  // address and no reset on the same edge.
  always_comb begin
    wr_accept = 1'b0;
    if ((bus.regwrite === 1'b1) && addr_known && !rst &&
        (bus.wr_addr != '0))
      wr_accept = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      count <= '0;
    end else if (wr_accept) begin
      regs[bus.wr_addr] <= bus.wr_data;
      if (count != 8'hFF)
        count <= count + 8'd1;
    end
  end

  // Address 0 is forced to zero on the read side as well, so it reads zero
  // even before the first reset has cleared the array.
  always_comb begin
    bus.rd_data1 = '0;
    if (bus.rd_addr1 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && (bus.wr_addr == bus.rd_addr1))
        bus.rd_data1 = bus.wr_data;
      else
        bus.rd_data1 = regs[bus.rd_addr1];
`else
      bus.rd_data1 = regs[bus.rd_addr1];
`endif
    end
  end

  always_comb begin
    bus.rd_data2 = '0;
    if (bus.rd_addr2 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && (bus.wr_addr == bus.rd_addr2))
        bus.rd_data2 = bus.wr_data;
      else
        bus.rd_data2 = regs[bus.rd_addr2];
`else
      bus.rd_data2 = regs[bus.rd_addr2];
`endif
    end
  end

  assign bus.wr_count = count;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed self-checking bench for reg_file_wb.
// Inputs are driven on the falling edge; outputs are sampled shortly after,
// well away from the rising edge where state changes.
module tb_reg_file_wb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_wb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.regwrite = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.regwrite = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr1 = a[4:0];
      bus.rd_addr2 = 5'(31 - a);
      #1;
      total++;
      if (bus.rd_data1 !== 32'h0) begin
        bad++;
        $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", a, bus.rd_data1, 32'h0);
      end
      total++;
      if (bus.rd_data2 !== 32'h0) begin
        bad++;
        $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - a, bus.rd_data2, 32'h0);
      end
    end
    total++;
    if (bus.wr_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", bus.wr_count);
    end
  endtask

  task automatic test_basic_write();
    do_write(5'd5, 32'h0000000A);
    do_write(5'd21, 32'h00000015);
    bus.rd_addr1 = 5'd5;
    bus.rd_addr2 = 5'd21;
    #1;
    total++;
    if (bus.rd_data1 !== 32'h0000000A) begin
      bad++;
      $display("FAIL basic_r5 got=%h exp=%h", bus.rd_data1, 32'h0000000A);
    end
    total++;
    if (bus.rd_data2 !== 32'h00000015) begin
      bad++;
      $display("FAIL basic_r21 got=%h exp=%h", bus.rd_data2, 32'h00000015);
    end
    total++;
    if (bus.wr_count !== 8'd2) begin
      bad++;
      $display("FAIL basic_count got=%0d exp=2", bus.wr_count);
    end
    // Both ports on one entry.
    bus.rd_addr2 = 5'd5;
    #1;
    total++;
    if (bus.rd_data2 !== 32'h0000000A) begin
      bad++;
      $display("FAIL same_addr_rd2 got=%h exp=%h", bus.rd_data2, 32'h0000000A);
    end
    // Neighbouring entries untouched.
    bus.rd_addr1 = 5'd4;
    bus.rd_addr2 = 5'd20;
    #1;
    total++;
    if ((bus.rd_data1 !== 32'h0) || (bus.rd_data2 !== 32'h0)) begin
      bad++;
      $display("FAIL basic_neighbours got=%h/%h exp=0/0", bus.rd_data1, bus.rd_data2);
    end
  endtask

  task automatic test_r0_protect();
    do_write(5'd0, 32'hFFFFFFFF);
    bus.rd_addr1 = 5'd0;
    bus.rd_addr2 = 5'd0;
    #1;
    total++;
    if (bus.rd_data1 !== 32'h0) begin
      bad++;
      $display("FAIL r0_rd1 got=%h exp=%h", bus.rd_data1, 32'h0);
    end
    total++;
    if (bus.rd_data2 !== 32'h0) begin
      bad++;
      $display("FAIL r0_rd2 got=%h exp=%h", bus.rd_data2, 32'h0);
    end
    total++;
    if (bus.wr_count !== 8'd2) begin
      bad++;
      $display("FAIL r0_count got=%0d exp=2", bus.wr_count);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_pre;
    do_write(5'd31, 32'h0000001F);
    @(negedge clk);
    bus.rd_addr1 = 5'd31;
    bus.rd_addr2 = 5'd21;
    bus.regwrite = 1'b1;
    bus.wr_addr  = 5'd31;
    bus.wr_data  = 32'h0000001D;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h0000001D;
`else
    exp_pre = 32'h0000001F;
`endif
    total++;
    if (bus.rd_data1 !== exp_pre) begin
      bad++;
      $display("FAIL same_cycle_pre got=%h exp=%h", bus.rd_data1, exp_pre);
    end
    // The other port is on a different entry and must not see the bypass.
    total++;
    if (bus.rd_data2 !== 32'h00000015) begin
      bad++;
      $display("FAIL same_cycle_other got=%h exp=%h", bus.rd_data2, 32'h00000015);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    total++;
    if (bus.rd_data1 !== 32'h0000001D) begin
      bad++;
      $display("FAIL same_cycle_post got=%h exp=%h", bus.rd_data1, 32'h0000001D);
    end
    total++;
    if (bus.wr_count !== 8'd4) begin
      bad++;
      $display("FAIL same_cycle_count got=%0d exp=4", bus.wr_count);
    end
  endtask

  task automatic test_reset_priority();
    do_write(5'd10, 32'h00000007);
    @(negedge clk);
    rst          = 1'b1;
    bus.regwrite = 1'b1;
    bus.wr_addr  = 5'd10;
    bus.wr_data  = 32'h00000005;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    bus.rd_addr1 = 5'd10;
    bus.rd_addr2 = 5'd5;
    #1;
    total++;
    if (bus.rd_data1 !== 32'h0) begin
      bad++;
      $display("FAIL rst_prio_r10 got=%h exp=%h", bus.rd_data1, 32'h0);
    end
    total++;
    if (bus.rd_data2 !== 32'h0) begin
      bad++;
      $display("FAIL rst_prio_r5 got=%h exp=%h", bus.rd_data2, 32'h0);
    end
    total++;
    if (bus.wr_count !== 8'd0) begin
      bad++;
      $display("FAIL rst_prio_count got=%0d exp=0", bus.wr_count);
    end
  endtask

  task automatic test_saturation_xguard();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.regwrite = 1'b1;
      bus.wr_addr  = 5'd1;
      bus.wr_data  = 32'(i);
      if (i == 254) begin
        #1;
        total++;
        if (bus.wr_count !== 8'd254) begin
          bad++;
          $display("FAIL sat_count_254 got=%0d exp=254", bus.wr_count);
        end
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
    bus.rd_addr1 = 5'd1;
    #1;
    total++;
    if (bus.wr_count !== 8'd255) begin
      bad++;
      $display("FAIL sat_count got=%0d exp=255", bus.wr_count);
    end
    total++;
    if (bus.rd_data1 !== 32'd299) begin
      bad++;
      $display("FAIL sat_r1 got=%h exp=%h", bus.rd_data1, 32'd299);
    end
    // Write with an unknown address: nothing may change.
    @(negedge clk);
    bus.regwrite = 1'b1;
    bus.wr_addr  = 5'bxxxxx;
    bus.wr_data  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    idle_inputs();
    for (int a = 0; a < 32; a++) begin
      logic [31:0] exp_v;
      bus.rd_addr1 = a[4:0];
      bus.rd_addr2 = a[4:0];
      exp_v = (a == 1) ? 32'd299 : 32'h0;
      #1;
      total++;
      if ((bus.rd_data1 !== exp_v) || (bus.rd_data2 !== exp_v)) begin
        bad++;
        $display("FAIL xguard_reg addr=%0d got=%h/%h exp=%h", a, bus.rd_data1, bus.rd_data2, exp_v);
      end
    end
    total++;
    if (bus.wr_count !== 8'd255) begin
      bad++;
      $display("FAIL xguard_count got=%0d exp=255", bus.wr_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_inputs();
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic_write();
    test_r0_protect();
    test_same_cycle();
    test_reset_priority();
    test_saturation_xguard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
